// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_mem staging buffer.
// The status struct bundles every flag the top level decodes each cycle.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // One extra MSB so equal low bits can be told apart as full or empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself carries no reset; only the read register does.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-address read and write returns the old word.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_mem.sv
// Synchronous FIFO: pointers, occupancy, threshold flags, sticky errors
// and a synchronous flush around a fifo_ram storage array.
module fifo_mem #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           Datain,
    input  logic                       rd,
    output logic [WIDTH-1:0]           Dataout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    import fifo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT   = PW'(AE_LEVEL);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          dout_valid_q, dout_valid_d;
    logic          wr_acc, rd_acc;
    logic          ram_we, ram_re;
    fifo_status_t  status;

    // Flags come only from registered state, never from rd/wr.
    always_comb begin
        status.full         = (count_q == FULL_CNT);
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= AF_CNT);
        status.almost_empty = (count_q <= AE_CNT);
        status.overflow     = overflow_q;
        status.underflow    = underflow_q;
    end

    always_comb begin
        rd_acc       = rd & ~status.empty;
        wr_acc       = wr & (~status.full | rd_acc);
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        dout_valid_d = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        if (clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            ram_we       = wr_acc;
            ram_re       = rd_acc;
            dout_valid_d = rd_acc;
            if (wr_acc) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (rd_acc) begin
                rptr_d = rptr_q + PW'(1);
            end
            overflow_d  = overflow_q | (wr & ~wr_acc);
            underflow_d = underflow_q | (rd & status.empty);
        end
        count_d = wptr_d - rptr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst),
        .we    (ram_we),
        .waddr (wptr_q[AW-1:0]),
        .wdata (Datain),
        .re    (ram_re),
        .raddr (rptr_q[AW-1:0]),
        .rdata (Dataout)
    );

    assign dout_valid   = dout_valid_q;
    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_mem.sv
// Directed bench for fifo_mem (WIDTH=8, DEPTH=4, AF=3, AE=1): vector
// tables with hand-computed results plus hand sequences for wrap and reset.
module tb_fifo_mem;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       wr;
    logic [7:0] Datain;
    logic       rd;
    logic [7:0] Dataout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       clr;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [2:0] cnt;
        logic [7:0] dout;
        logic       dv;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];

    fifo_mem #(
        .WIDTH    (8),
        .DEPTH    (4),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .wr           (wr),
        .Datain       (Datain),
        .rd           (rd),
        .Dataout      (Dataout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t v(input logic c, input logic w, input logic r,
                               input logic [7:0] din, input logic [2:0] cnt,
                               input logic [7:0] dout, input logic dv,
                               input logic f, input logic e, input logic af,
                               input logic ae, input logic o, input logic u);
        vec_t t;
        t.clr = c; t.wr = w; t.rd = r; t.din = din;
        t.cnt = cnt; t.dout = dout; t.dv = dv; t.full = f; t.empty = e;
        t.af = af; t.ae = ae; t.ovf = o; t.unf = u;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".count"},        32'(count),        32'(e.cnt));
        chk({tag, ".Dataout"},      32'(Dataout),      32'(e.dout));
        chk({tag, ".dout_valid"},   32'(dout_valid),   32'(e.dv));
        chk({tag, ".full"},         32'(full),         32'(e.full));
        chk({tag, ".empty"},        32'(empty),        32'(e.empty));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(e.af));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(e.ae));
        chk({tag, ".overflow"},     32'(overflow),     32'(e.ovf));
        chk({tag, ".underflow"},    32'(underflow),    32'(e.unf));
    endtask

    task automatic drive(input logic c, input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        clr = c; wr = w; rd = r; Datain = d;
    endtask

    task automatic run_tbl(input string name);
        int idx = 0;
        while (tbl.size() > 0) begin
            vec_t t = tbl.pop_front();
            drive(t.clr, t.wr, t.rd, t.din);
            @(posedge clk);
            #1;
            chk_all($sformatf("%s[%0d]", name, idx), t);
            idx++;
        end
        drive(0, 0, 0, 8'h00);
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; Datain = 8'h00;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", v(0,0,0,8'h00, 0,8'h00,0,0,1,0,1,0,0));
        @(negedge clk);
        rst = 1'b1;

        // fill/drain, overflow with simultaneous rd+wr at full, underflow on empty
        tbl.push_back(v(0,0,0,8'h00, 0,8'h00,0,0,1,0,1,0,0));
        tbl.push_back(v(0,1,0,8'hAA, 1,8'h00,0,0,0,0,1,0,0));
        tbl.push_back(v(0,1,0,8'hBB, 2,8'h00,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,8'hCC, 3,8'h00,0,0,0,1,0,0,0));
        tbl.push_back(v(0,1,0,8'hDD, 4,8'h00,0,1,0,1,0,0,0));
        tbl.push_back(v(0,0,1,8'h00, 3,8'hAA,1,0,0,1,0,0,0));
        tbl.push_back(v(0,0,1,8'h00, 2,8'hBB,1,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,8'h00, 1,8'hCC,1,0,0,0,1,0,0));
        tbl.push_back(v(0,0,1,8'h00, 0,8'hDD,1,0,1,0,1,0,0));
        tbl.push_back(v(0,0,0,8'h00, 0,8'hDD,0,0,1,0,1,0,0));
        tbl.push_back(v(0,1,0,8'hAA, 1,8'hDD,0,0,0,0,1,0,0));
        tbl.push_back(v(0,1,0,8'hBB, 2,8'hDD,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,8'hCC, 3,8'hDD,0,0,0,1,0,0,0));
        tbl.push_back(v(0,1,0,8'hDD, 4,8'hDD,0,1,0,1,0,0,0));
        tbl.push_back(v(0,1,0,8'hEE, 4,8'hDD,0,1,0,1,0,1,0));
        tbl.push_back(v(0,1,1,8'hEE, 4,8'hAA,1,1,0,1,0,1,0));
        tbl.push_back(v(0,0,1,8'h00, 3,8'hBB,1,0,0,1,0,1,0));
        tbl.push_back(v(0,0,1,8'h00, 2,8'hCC,1,0,0,0,0,1,0));
        tbl.push_back(v(0,0,1,8'h00, 1,8'hDD,1,0,0,0,1,1,0));
        tbl.push_back(v(0,0,1,8'h00, 0,8'hEE,1,0,1,0,1,1,0));
        tbl.push_back(v(1,0,0,8'h00, 0,8'hEE,0,0,1,0,1,0,0));
        tbl.push_back(v(0,1,1,8'h5A, 1,8'hEE,0,0,0,0,1,0,1));
        tbl.push_back(v(0,0,1,8'h00, 0,8'h5A,1,0,1,0,1,0,1));
        tbl.push_back(v(1,0,0,8'h00, 0,8'h5A,0,0,1,0,1,0,0));
        run_tbl("basic");

        // pointer wrap: 10 words streamed through with overlapped rd/wr
        drive(0, 1, 0, 8'd0);
        exp_q.push_back(8'd0);
        @(posedge clk);
        #1;
        chk("wrap.count0", 32'(count), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            logic [7:0] exp_d;
            if (i <= 9) begin
                drive(0, 1, 1, 8'(i));
                exp_q.push_back(8'(i));
            end else begin
                drive(0, 0, 1, 8'h00);
            end
            @(posedge clk);
            #1;
            exp_d = exp_q.pop_front();
            chk($sformatf("wrap[%0d].Dataout", i), 32'(Dataout), 32'(exp_d));
            chk($sformatf("wrap[%0d].dout_valid", i), 32'(dout_valid), 32'd1);
            chk($sformatf("wrap[%0d].count", i), 32'(count), (i <= 9) ? 32'd1 : 32'd0);
        end
        drive(0, 0, 0, 8'h00);
        @(posedge clk);
        #1;
        chk_all("wrap.end", v(0,0,0,8'h00, 0,8'd9,0,0,1,0,1,0,0));

        // flush with a concurrent write while holding entries and an error
        tbl.push_back(v(0,1,0,8'h11, 1,8'h09,0,0,0,0,1,0,0));
        tbl.push_back(v(0,1,0,8'h22, 2,8'h09,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,8'h33, 3,8'h09,0,0,0,1,0,0,0));
        tbl.push_back(v(0,1,0,8'h44, 4,8'h09,0,1,0,1,0,0,0));
        tbl.push_back(v(0,1,0,8'h55, 4,8'h09,0,1,0,1,0,1,0));
        tbl.push_back(v(0,0,1,8'h00, 3,8'h11,1,0,0,1,0,1,0));
        tbl.push_back(v(1,1,0,8'h66, 0,8'h11,0,0,1,0,1,0,0));
        tbl.push_back(v(0,0,1,8'h00, 0,8'h11,0,0,1,0,1,0,1));
        tbl.push_back(v(1,0,0,8'h00, 0,8'h11,0,0,1,0,1,0,0));
        run_tbl("flush");

        // asynchronous reset in the middle of a cycle with 3 words stored
        tbl.push_back(v(0,1,0,8'h77, 1,8'h11,0,0,0,0,1,0,0));
        tbl.push_back(v(0,1,0,8'h88, 2,8'h11,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,8'h00, 1,8'h77,1,0,0,0,1,0,0));
        tbl.push_back(v(0,1,0,8'h99, 2,8'h77,0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,8'hAB, 3,8'h77,0,0,0,1,0,0,0));
        run_tbl("prerst");
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", v(0,0,0,8'h00, 0,8'h00,0,0,1,0,1,0,0));
        @(posedge clk);
        #1;
        chk_all("rst_hold", v(0,0,0,8'h00, 0,8'h00,0,0,1,0,1,0,0));
        @(negedge clk);
        rst = 1'b1;
        rd  = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst_rd", v(0,0,0,8'h00, 0,8'h00,0,0,1,0,1,0,1));
        drive(0, 0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_mem.md
# fifo_mem

Parametrised synchronous FIFO buffer: the successor to the team's single-register 8-bit `rd`/`wr` memory, generalised to `WIDTH` × `DEPTH` storage. Adds full/empty/occupancy status, programmable almost-full/almost-empty thresholds, sticky overflow/underflow errors and a synchronous flush. It sits between a producer and a consumer in the same clock domain as the general-purpose staging buffer.

## Interface
- `WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 16: number of entries; must be a power of 2, ≥2.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when count ≥ AF_LEVEL.
- `AE_LEVEL`, 2: `almost_empty` asserts when count ≤ AE_LEVEL.
- `AW`: derived, $clog2(DEPTH). Local; not overridable.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous flush; empties the FIFO and clears errors.
- `wr`  in  1  write request.
- `Datain`  in  WIDTH  write data, sampled with `wr`.
- `rd`  in  1  read request.
- `Dataout`  out  WIDTH  registered read data.
- `dout_valid`  out  1  one-cycle pulse: `Dataout` holds a newly popped word.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `almost_empty`  out  1  count ≤ AE_LEVEL.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was attempted while full and not accepted.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Storage: DEPTH×WIDTH array. Write pointer and read pointer are each AW+1 bits; the extra MSB disambiguates full from empty. Pointers wrap modulo 2·DEPTH. The array is indexed by the low AW bits.
- Write accept: `wr_acc = wr & (!full | rd_acc)`. Words are stored at `wptr`, then `wptr` is incremented.
- Read accept: `rd_acc = rd & !empty`. Data is read from `rptr` into `Dataout`, then `rptr` is incremented.
- Simultaneous `rd` and `wr`:
  - Non-empty, non-full: both are accepted; count is unchanged.
  - Empty: the write is accepted and the read is rejected; `underflow` is set. There is no fall-through.
  - Full: both are accepted; count stays at DEPTH; `overflow` is not set.
- Rejected write (full, no `rd_acc`): `overflow` is set. Data and pointers are unchanged.
- Rejected read (empty): `underflow` is set. `Dataout` holds its last value and `dout_valid` is 0.
- `clr` has priority over `rd` and `wr` in the same cycle:
  - Pointers, count, `overflow`, `underflow` and `dout_valid` go to 0.
  - `Dataout` holds its value.
  - Array contents are not cleared.
- `count = wptr - rptr` (AW+1-bit subtraction), registered. All flags are decoded from registered pointers and count.

## Timing
- Reset (`rst` low, asynchronous):
  - `Dataout`=0, `dout_valid`=0, `empty`=1, `full`=0, `count`=0.
  - `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0.
  - Array contents are undefined.
- Reset deassertion takes effect at the first rising edge after `rst` goes high.
- Reset asserted mid-operation discards all stored words immediately.
- Read latency: with `rd` high at edge N and the FIFO non-empty, `Dataout` and `dout_valid` update after edge N, i.e. visible in cycle N+1.
- Write-to-read: a word written at edge N makes `empty` fall after edge N. It can be popped at edge N+1 and appears in cycle N+2.
- All status outputs reflect the state after the current edge. There is no combinational path from `rd`/`wr` to any output.
- Back-to-back reads and writes are sustained at one word per cycle each.

## Structure
- Shared package `fifo_pkg`:
  - `fifo_status_t` struct bundling full, empty, almost_full, almost_empty, overflow, underflow.
  - Local constant/function for the pointer width (AW+1).
- Sub-module `fifo_ram`: simple dual-port array with one write port and one registered read port (`we`, `waddr`, `wdata`, `re`, `raddr`, `rdata`). No reset on the array.
- Top level holds the pointers, count, flag decode, sticky errors and `dout_valid`.

## Test plan
Use WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
1. Reset, then idle: `empty`=1, `count`=0, `Dataout`=8'h00, `almost_empty`=1, errors 0.
2. Write 8'hAA, 8'hBB, 8'hCC, 8'hDD, then read four times:
   - `count` goes 1,2,3,4; `almost_full` rises at 3; `full`=1 at 4.
   - `Dataout` = AA,BB,CC,DD, each with a `dout_valid` pulse one cycle after its `rd`.
3. Fill to 4, then issue `wr` 8'hEE alone: `overflow`=1 and `count` stays 4. Next, `rd`+`wr` 8'hEE together: `Dataout`=AA, `count`=4, and EE is stored as the last entry.
4. On an empty FIFO, assert `rd`+`wr` 8'h5A together: `underflow`=1, `count`=1, `dout_valid`=0. Then `rd`: `Dataout`=5A.
5. Run 10 write/read pairs with data 0..9 to force pointer wrap: output order is 0..9, `count` ends at 0, no errors.
6. Cover both mid-operation events:
   - With 3 entries stored, assert `clr` together with `wr`: `count`=0, `empty`=1, errors cleared, the write is dropped.
   - Repeat with `rst` pulsed low mid-cycle: outputs reach their reset values asynchronously.
